multi_cycle_control_unit: RTL

FSM control unit for the RV32I multi-cycle CPU. It succeeds the single-cycle combinational decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the shared ALU, memory, IR, PC and register-file enables, stalls on a memory-ready handshake, halts on ECALL, and counts retired instructions.

---
 rtl/multi_cycle_control_unit.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/multi_cycle_control_unit.sv
// multi_cycle_control_unit: RV32I multi-cycle FSM sequencer with ready stalls, ECALL halt and retire counter
module multi_cycle_control_unit #(
  parameter bit USE_MEM_READY   = 1'b1,
  parameter int CNT_W           = 32,
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             bcond,
  input  logic             mem_ready,
  input  logic             ecall_halt,
  output logic             pc_write,
  output logic             pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             is_halted,
  output logic             illegal_inst,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired_count
);
  typedef enum logic [3:0] {
    S_IF = 4'd0, S_ID = 4'd1, S_EX = 4'd2, S_MEM_RD = 4'd3, S_MEM_WR = 4'd4,
    S_WB = 4'd5, S_WB_LD = 4'd6, S_BR_NT = 4'd7, S_JALR_WB = 4'd8, S_HALT = 4'd9
  } state_t;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011,
    OP_SW = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
    OP_ECALL = 7'b1110011;
  state_t cur, nxt;
  logic retire;
  logic rdy;
  assign rdy = USE_MEM_READY ? mem_ready : 1'b1;
  assign state = cur;
  // state register and retired-instruction counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur <= S_IF;
      retired_count <= '0;
    end else begin
      cur <= nxt;
      if (retire) retired_count <= retired_count + CNT_W'(1);
    end
  end
  // next state and control outputs; everything forced low while reset is held
  always_comb begin
    nxt = S_IF;
    retire = 1'b0;
    pc_write = 1'b0;
    pc_source = 1'b0;
    i_or_d = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    reg_write = 1'b0;
    wb_sel = 2'd0;
    alu_src_a = 1'b0;
    alu_src_b = 2'd0;
    alu_op = 2'd0;
    is_halted = 1'b0;
    illegal_inst = 1'b0;
    case (cur)
      S_IF: begin
        mem_read = 1'b1;
        alu_src_b = 2'd1;
        ir_write = rdy;
        nxt = rdy ? S_ID : S_IF;
      end
      S_ID: begin
        alu_src_b = 2'd2;
        case (opcode)
          OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR: nxt = S_EX;
          OP_ECALL: begin
            if (ecall_halt) nxt = S_HALT;
            else begin
              alu_src_b = 2'd1;
              pc_write = 1'b1;
              retire = 1'b1;
            end
          end
          default: begin
            illegal_inst = 1'b1;
            if (HALT_ON_ILLEGAL) nxt = S_HALT;
            else begin
              alu_src_b = 2'd1;
              pc_write = 1'b1;
            end
          end
        endcase
      end
      S_EX: begin
        case (opcode)
          OP_R: begin
            alu_src_a = 1'b1;
            alu_op = 2'd2;
            nxt = S_WB;
          end
          OP_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            alu_op = 2'd2;
            nxt = S_WB;
          end
          OP_LW, OP_SW, OP_JALR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            nxt = opcode == OP_LW ? S_MEM_RD : opcode == OP_SW ? S_MEM_WR : S_JALR_WB;
          end
          OP_BR: begin
            alu_src_a = 1'b1;
            alu_op = 2'd1;
            pc_write = bcond;
            pc_source = bcond;
            retire = bcond;
            nxt = bcond ? S_IF : S_BR_NT;
          end
          OP_JAL: begin
            alu_src_b = 2'd1;
            reg_write = 1'b1;
            wb_sel = 2'd2;
            pc_write = 1'b1;
            pc_source = 1'b1;
            retire = 1'b1;
          end
          default: nxt = S_IF;
        endcase
      end
      S_MEM_RD: begin
        i_or_d = 1'b1;
        mem_read = 1'b1;
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        nxt = rdy ? S_WB_LD : S_MEM_RD;
      end
      S_MEM_WR: begin
        i_or_d = 1'b1;
        mem_write = 1'b1;
        alu_src_a = !rdy;
        alu_src_b = rdy ? 2'd1 : 2'd2;
        pc_write = rdy;
        retire = rdy;
        nxt = rdy ? S_IF : S_MEM_WR;
      end
      S_WB, S_WB_LD: begin
        reg_write = 1'b1;
        wb_sel = cur == S_WB_LD ? 2'd1 : 2'd0;
        alu_src_b = 2'd1;
        pc_write = 1'b1;
        retire = 1'b1;
      end
      S_BR_NT: begin
        alu_src_b = 2'd1;
        pc_write = 1'b1;
        retire = 1'b1;
      end
      S_JALR_WB: begin
        alu_src_b = 2'd1;
        reg_write = 1'b1;
        wb_sel = 2'd2;
        pc_write = 1'b1;
        pc_source = 1'b1;
        retire = 1'b1;
      end
      S_HALT: begin
        is_halted = 1'b1;
        nxt = S_HALT;
      end
      default: nxt = S_IF;
    endcase
    if (!reset) begin
      pc_write = 1'b0;
      pc_source = 1'b0;
      i_or_d = 1'b0;
      mem_read = 1'b0;
      mem_write = 1'b0;
      ir_write = 1'b0;
      reg_write = 1'b0;
      wb_sel = 2'd0;
      alu_src_a = 1'b0;
      alu_src_b = 2'd0;
      alu_op = 2'd0;
      is_halted = 1'b0;
      illegal_inst = 1'b0;
      retire = 1'b0;
    end
  end
endmodule
